// File: rtl/core_memory_arbiter_pkg.sv
// Shared types and constants for the core memory arbiter and its timeout counter.
package core_memory_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } arb_state_t;

    localparam logic [3:0] FULL_WORD_SELECT = 4'b1111;

    function automatic int timeout_count_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/core_memory_arbiter_if.sv
// Pipeline-side and memory-side signals of the arbiter; master is the arbiter's view.
interface core_memory_arbiter_if;

    logic        requestingInstruction;
    logic [31:0] fetchAddress;
    logic [31:0] fetchData;
    logic        fetchError;
    logic        instructionBusy;

    logic        requestingData;
    logic        dataWriteEnable;
    logic [3:0]  dataByteSelect;
    logic [31:0] dataAddress;
    logic [31:0] dataWriteData;
    logic [31:0] dataReadData;
    logic        dataError;
    logic        dataBusy;

    logic        memoryRequest;
    logic [31:0] memoryAddress;
    logic        memoryWriteEnable;
    logic [3:0]  memoryByteSelect;
    logic [31:0] memoryWriteData;
    logic [31:0] memoryReadData;
    logic        memoryAck;

    modport master (
        input  requestingInstruction, fetchAddress,
        input  requestingData, dataWriteEnable, dataByteSelect, dataAddress, dataWriteData,
        input  memoryReadData, memoryAck,
        output fetchData, fetchError, instructionBusy,
        output dataReadData, dataError, dataBusy,
        output memoryRequest, memoryAddress, memoryWriteEnable, memoryByteSelect, memoryWriteData
    );

    modport slave (
        output requestingInstruction, fetchAddress,
        output requestingData, dataWriteEnable, dataByteSelect, dataAddress, dataWriteData,
        output memoryReadData, memoryAck,
        input  fetchData, fetchError, instructionBusy,
        input  dataReadData, dataError, dataBusy,
        input  memoryRequest, memoryAddress, memoryWriteEnable, memoryByteSelect, memoryWriteData
    );

endinterface

// File: rtl/core_memory_arbiter_timeout_counter.sv
// Counts cycles a transaction waits for ack; expired marks the cycle the wait reaches the limit.
module memory_timeout_counter
    import core_memory_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);

    localparam int                CNT_W = timeout_count_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // The current waiting cycle is the last allowed one when the count already holds limit-1.
    assign o_expired = i_run && (r_count == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_run && !o_expired) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/core_memory_arbiter.sv
// Serialises fetch and load/store requests onto one request/ack memory port,
// data first, with a timeout so a dead target cannot stall the core.
module core_memory_arbiter
    import core_memory_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    core_memory_arbiter_if.master bus
);

    arb_state_t  r_state;
    arb_state_t  w_next_state;
    logic        w_completing;
    logic        w_fetch_done;
    logic        w_data_done;
    logic        w_load_done;
    logic        w_leave_idle;
    logic        w_mem_req;
    logic        w_expired;
    logic [31:0] w_done_word;
    logic        w_unused_addr_bits;

    logic [31:0] r_mem_addr;
    logic        r_mem_we;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_wdata;
    logic [31:0] r_fetch_data;
    logic [31:0] r_load_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_completing = 1'b0;
        w_fetch_done = 1'b0;
        w_data_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.requestingData) begin
                    w_next_state = DATA;
                end else if (bus.requestingInstruction) begin
                    w_next_state = FETCH;
                end
            end
            FETCH: begin
                w_completing = bus.memoryAck || w_expired;
                w_fetch_done = w_completing;
                if (w_completing) w_next_state = IDLE;
            end
            DATA: begin
                w_completing = bus.memoryAck || w_expired;
                w_data_done  = w_completing;
                if (w_completing) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign w_mem_req    = (r_state != IDLE);
    assign w_leave_idle = (r_state == IDLE) && (w_next_state != IDLE);
    assign w_load_done  = w_data_done && !r_mem_we;
    // A timed-out completion returns zero rather than whatever is on the read bus.
    assign w_done_word  = bus.memoryAck ? bus.memoryReadData : 32'h0;
    assign w_unused_addr_bits = ^{bus.fetchAddress[1:0], bus.dataAddress[1:0]};

    memory_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_leave_idle),
        .i_run    (w_mem_req && !bus.memoryAck),
        .o_expired(w_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_be     <= '0;
            r_mem_wdata  <= '0;
            r_fetch_data <= '0;
            r_load_data  <= '0;
        end else begin
            if (w_leave_idle) begin
                if (w_next_state == DATA) begin
                    r_mem_addr  <= {bus.dataAddress[31:2], 2'b00};
                    r_mem_we    <= bus.dataWriteEnable;
                    r_mem_be    <= bus.dataByteSelect;
                    r_mem_wdata <= bus.dataWriteData;
                end else begin
                    r_mem_addr  <= {bus.fetchAddress[31:2], 2'b00};
                    r_mem_we    <= 1'b0;
                    r_mem_be    <= FULL_WORD_SELECT;
                    r_mem_wdata <= '0;
                end
            end
            // Latches update even if the requester withdrew before completion.
            if (w_fetch_done) r_fetch_data <= w_done_word;
            if (w_load_done)  r_load_data  <= w_done_word;
        end
    end

    assign bus.memoryRequest     = w_mem_req;
    assign bus.memoryAddress     = r_mem_addr;
    assign bus.memoryWriteEnable = r_mem_we;
    assign bus.memoryByteSelect  = r_mem_be;
    assign bus.memoryWriteData   = r_mem_wdata;

    assign bus.instructionBusy = bus.requestingInstruction && !w_fetch_done;
    assign bus.dataBusy        = bus.requestingData && !w_data_done;
    assign bus.fetchError      = w_fetch_done && !bus.memoryAck;
    assign bus.dataError       = w_data_done && !bus.memoryAck;
    assign bus.fetchData       = w_fetch_done ? w_done_word : r_fetch_data;
    assign bus.dataReadData    = w_load_done ? w_done_word : r_load_data;

endmodule

// File: tb/tb_core_memory_arbiter.sv
// Directed and randomized bench for core_memory_arbiter against a transaction-level model.
module tb_core_memory_arbiter;

    localparam int T       = 4;
    localparam int K_FETCH = 1;
    localparam int K_DATA  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    core_memory_arbiter_if bus();

    core_memory_arbiter #(
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Outstanding-transaction model
    bit          out_valid = 1'b0;
    int          out_kind  = 0;
    int          out_age   = 0;
    logic [31:0] out_addr  = '0;
    logic        out_we    = 1'b0;
    logic [3:0]  out_be    = '0;
    logic [31:0] out_wd    = '0;
    logic [31:0] lat_f     = '0;
    logic [31:0] lat_d     = '0;
    int          ack_delay = 0;

    // Snapshot of DUT outputs from the last checked cycle
    logic        s_mreq, s_ibusy, s_dbusy, s_ferr, s_derr, s_mwe;
    logic [31:0] s_maddr, s_mwd, s_fdata, s_drd;
    logic [3:0]  s_mbe;
    int          n_req, n_ibusy, n_dbusy, n_ferr, n_derr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Checks one clock cycle against the model, then advances to just after the next rising edge.
    task automatic tick();
        bit          comp, fd, dd;
        logic [31:0] dw;
        @(negedge clk);
        if (!rst) begin
            out_valid = 1'b0;
            out_age   = 0;
            lat_f     = '0;
            lat_d     = '0;
        end
        comp = out_valid && (bus.memoryAck || (out_age + 1 == T));
        fd   = comp && (out_kind == K_FETCH);
        dd   = comp && (out_kind == K_DATA);
        dw   = bus.memoryAck ? bus.memoryReadData : 32'h0;

        s_mreq  = bus.memoryRequest;   s_ibusy = bus.instructionBusy; s_dbusy = bus.dataBusy;
        s_ferr  = bus.fetchError;      s_derr  = bus.dataError;       s_mwe   = bus.memoryWriteEnable;
        s_maddr = bus.memoryAddress;   s_mwd   = bus.memoryWriteData; s_mbe   = bus.memoryByteSelect;
        s_fdata = bus.fetchData;       s_drd   = bus.dataReadData;

        check("memoryRequest",   32'(s_mreq),  32'(out_valid));
        check("instructionBusy", 32'(s_ibusy), 32'(bus.requestingInstruction && !fd));
        check("dataBusy",        32'(s_dbusy), 32'(bus.requestingData && !dd));
        check("fetchError",      32'(s_ferr),  32'(fd && !bus.memoryAck));
        check("dataError",       32'(s_derr),  32'(dd && !bus.memoryAck));
        check("fetchData",       s_fdata,      fd ? dw : lat_f);
        check("dataReadData",    s_drd,        (dd && !out_we) ? dw : lat_d);
        if (out_valid) begin
            check("memoryAddress",     s_maddr,     out_addr);
            check("memoryWriteEnable", 32'(s_mwe),  32'(out_we));
            check("memoryByteSelect",  32'(s_mbe),  32'(out_be));
            check("memoryWriteData",   s_mwd,       out_wd);
        end

        n_req   += int'(s_mreq);
        n_ibusy += int'(s_ibusy);
        n_dbusy += int'(s_dbusy);
        n_ferr  += int'(s_ferr);
        n_derr  += int'(s_derr);

        if (fd) lat_f = dw;
        if (dd && !out_we) lat_d = dw;
        if (comp) begin
            out_valid = 1'b0;
        end else if (out_valid) begin
            out_age++;
        end else if (rst && bus.requestingData) begin
            out_valid = 1'b1; out_age = 0; out_kind = K_DATA;
            out_addr  = bus.dataAddress & ~32'h3;
            out_we    = bus.dataWriteEnable;
            out_be    = bus.dataByteSelect;
            out_wd    = bus.dataWriteData;
        end else if (rst && bus.requestingInstruction) begin
            out_valid = 1'b1; out_age = 0; out_kind = K_FETCH;
            out_addr  = bus.fetchAddress & ~32'h3;
            out_we    = 1'b0;
            out_be    = 4'b1111;
            out_wd    = 32'h0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.requestingInstruction = 1'b0; bus.fetchAddress = '0;
        bus.requestingData = 1'b0; bus.dataWriteEnable = 1'b0; bus.dataByteSelect = '0;
        bus.dataAddress = '0; bus.dataWriteData = '0;
        bus.memoryReadData = '0; bus.memoryAck = 1'b0;
        n_req = 0; n_ibusy = 0; n_dbusy = 0; n_ferr = 0; n_derr = 0;

        // Reset values, busy mirrors request during reset
        @(posedge clk); #1;
        tick();
        bus.requestingInstruction = 1'b1;
        tick();
        check("rst_ibusy_follows_req", 32'(s_ibusy), 32'd1);
        check("rst_memoryAddress", s_maddr, 32'h0);
        check("rst_memoryByteSelect", 32'(s_mbe), 32'h0);
        bus.requestingInstruction = 1'b0;
        rst = 1'b1;
        tick();

        // Single fetch, ack in the 4th request cycle
        bus.requestingInstruction = 1'b1; bus.fetchAddress = 32'h1003;
        n_ibusy = 0; n_req = 0; n_ferr = 0;
        tick();
        tick();
        check("fetch_addr", s_maddr, 32'h1000);
        check("fetch_be", 32'(s_mbe), 32'hF);
        tick(); tick();
        bus.memoryAck = 1'b1; bus.memoryReadData = 32'hDEADBEEF;
        tick();
        check("fetch_data_pass", s_fdata, 32'hDEADBEEF);
        bus.memoryAck = 1'b0; bus.requestingInstruction = 1'b0; bus.memoryReadData = 32'h0;
        tick();
        check("fetch_data_held", s_fdata, 32'hDEADBEEF);
        check("fetch_busy_cycles", 32'(n_ibusy), 32'd4);
        check("fetch_req_cycles", 32'(n_req), 32'd4);
        check("fetch_no_error", 32'(n_ferr), 32'd0);

        // Simultaneous store and fetch: store first, fetch after one idle cycle
        bus.requestingData = 1'b1; bus.dataWriteEnable = 1'b1; bus.dataAddress = 32'h2000;
        bus.dataWriteData = 32'h12345678; bus.dataByteSelect = 4'b0011;
        bus.requestingInstruction = 1'b1; bus.fetchAddress = 32'h3000;
        tick();
        tick();
        check("sim_store_addr", s_maddr, 32'h2000);
        check("sim_store_we", 32'(s_mwe), 32'd1);
        check("sim_store_be", 32'(s_mbe), 32'h3);
        check("sim_store_wd", s_mwd, 32'h12345678);
        bus.memoryAck = 1'b1; bus.memoryReadData = 32'h99999999;
        tick();
        check("sim_dbusy_drop", 32'(s_dbusy), 32'd0);
        check("sim_ibusy_held", 32'(s_ibusy), 32'd1);
        bus.memoryAck = 1'b0; bus.requestingData = 1'b0;
        tick();
        check("sim_gap_idle", 32'(s_mreq), 32'd0);
        tick();
        check("sim_fetch_issued", 32'(s_mreq), 32'd1);
        check("sim_fetch_addr", s_maddr, 32'h3000);
        bus.memoryAck = 1'b1; bus.memoryReadData = 32'hCAFEF00D;
        tick();
        check("sim_ibusy_drop", 32'(s_ibusy), 32'd0);
        check("sim_fetch_data", s_fdata, 32'hCAFEF00D);
        bus.memoryAck = 1'b0; bus.requestingInstruction = 1'b0;
        tick();

        // Minimum-latency load
        bus.requestingData = 1'b1; bus.dataWriteEnable = 1'b0; bus.dataAddress = 32'h4012;
        bus.dataByteSelect = 4'b1111; n_dbusy = 0;
        tick();
        bus.memoryAck = 1'b1; bus.memoryReadData = 32'hA5A50F0F;
        tick();
        check("load_min_data", s_drd, 32'hA5A50F0F);
        bus.memoryAck = 1'b0; bus.requestingData = 1'b0;
        tick();
        check("load_min_busy_cycles", 32'(n_dbusy), 32'd1);

        // Load timeout: no ack
        bus.requestingData = 1'b1; bus.dataAddress = 32'h4020;
        tick();
        n_req = 0; n_derr = 0;
        tick(); tick(); tick(); tick();
        check("timeout_err_pulse", 32'(s_derr), 32'd1);
        check("timeout_data_zero", s_drd, 32'h0);
        check("timeout_dbusy_drop", 32'(s_dbusy), 32'd0);
        bus.requestingData = 1'b0;
        tick();
        check("timeout_req_low", 32'(s_mreq), 32'd0);
        check("timeout_req_cycles", 32'(n_req), 32'd4);
        check("timeout_err_count", 32'(n_derr), 32'd1);

        // Ack on the timeout cycle wins
        bus.requestingData = 1'b1; bus.dataAddress = 32'h4030;
        tick();
        n_derr = 0;
        tick(); tick(); tick();
        bus.memoryAck = 1'b1; bus.memoryReadData = 32'h0BADF00D;
        tick();
        check("ack_at_limit_data", s_drd, 32'h0BADF00D);
        bus.memoryAck = 1'b0; bus.requestingData = 1'b0;
        tick();
        check("ack_at_limit_no_err", 32'(n_derr), 32'd0);

        // Fetch withdrawn mid-transaction
        bus.requestingInstruction = 1'b1; bus.fetchAddress = 32'h5000;
        tick(); tick();
        bus.requestingInstruction = 1'b0;
        tick();
        bus.memoryAck = 1'b1; bus.memoryReadData = 32'h11112222;
        tick();
        check("withdraw_latched", s_fdata, 32'h11112222);
        bus.memoryAck = 1'b0;
        tick(); tick();
        check("withdraw_no_reissue", 32'(s_mreq), 32'd0);
        bus.requestingInstruction = 1'b1; bus.fetchAddress = 32'h6004;
        tick(); tick();
        check("withdraw_next_addr", s_maddr, 32'h6004);
        bus.memoryAck = 1'b1; bus.memoryReadData = 32'h33334444;
        tick();
        bus.memoryAck = 1'b0; bus.requestingInstruction = 1'b0;
        tick();

        // Reset mid-DATA
        bus.requestingData = 1'b1; bus.dataWriteEnable = 1'b1; bus.dataAddress = 32'h7000;
        bus.dataWriteData = 32'h77770000; bus.dataByteSelect = 4'b1100;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("reset_async_req", 32'(bus.memoryRequest), 32'd0);
        tick();
        check("reset_maddr", s_maddr, 32'h0);
        check("reset_mwd", s_mwd, 32'h0);
        check("reset_mwe", 32'(s_mwe), 32'd0);
        check("reset_fdata", s_fdata, 32'h0);
        check("reset_dbusy", 32'(s_dbusy), 32'd1);
        rst = 1'b1;
        tick(); tick();
        check("reset_restart_addr", s_maddr, 32'h7000);
        bus.memoryAck = 1'b1;
        tick();
        bus.memoryAck = 1'b0; bus.requestingData = 1'b0;
        tick();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (bus.requestingInstruction) begin
                if (!s_ibusy) bus.requestingInstruction = ($urandom_range(0, 1) == 0);
                else if ($urandom_range(0, 39) == 0) bus.requestingInstruction = 1'b0;
            end else begin
                bus.requestingInstruction = ($urandom_range(0, 2) == 0);
            end
            if (bus.requestingData) begin
                if (!s_dbusy) bus.requestingData = ($urandom_range(0, 1) == 0);
                else if ($urandom_range(0, 39) == 0) bus.requestingData = 1'b0;
            end else begin
                bus.requestingData = ($urandom_range(0, 3) == 0);
            end
            bus.fetchAddress    = $urandom;
            bus.dataAddress     = $urandom;
            bus.dataWriteData   = $urandom;
            bus.dataByteSelect  = 4'($urandom);
            bus.dataWriteEnable = 1'($urandom);
            bus.memoryReadData  = $urandom;
            if (out_valid) begin
                if (out_age == 0) ack_delay = int'($urandom_range(0, 5));
                bus.memoryAck = (out_age == ack_delay);
            end else begin
                bus.memoryAck = ($urandom_range(0, 3) == 0);
            end
            tick();
        end
        bus.requestingInstruction = 1'b0; bus.requestingData = 1'b0; bus.memoryAck = 1'b0;
        repeat (T + 2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_memory_arbiter.md
# core_memory_arbiter

Single-master memory front end for the core. It accepts the instruction-fetch and load/store requests issued by the pipeline and serialises them onto one request/acknowledge memory port. It drives `instructionBusy` and `dataBusy` back to the pipeline flow controller, which gates pipeline stepping on `requesting && busy`. A timeout guarantees that a dead target cannot hang the core.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum cycles `memoryRequest` stays high without `memoryAck` before forced completion; legal range 1..65535.

Ports:
- `clk`  in  1  core clock; every register is clocked on the rising edge.
- `rst`  in  1  reset, asynchronous assert, active-low (`rst == 0` resets).
- `requestingInstruction`  in  1  fetch request; held until the cycle `instructionBusy` is low.
- `fetchAddress`  in  32  fetch byte address; bits [1:0] are ignored.
- `fetchData`  out  32  fetched word.
- `fetchError`  out  1  one-cycle pulse on a timed-out fetch completion.
- `instructionBusy`  out  1  fetch not yet complete.
- `requestingData`  in  1  load/store request; held until `dataBusy` is low.
- `dataWriteEnable`  in  1  1 means store, 0 means load.
- `dataByteSelect`  in  4  byte lanes.
- `dataAddress`  in  32  byte address; bits [1:0] are ignored.
- `dataWriteData`  in  32  store data.
- `dataReadData`  out  32  load data.
- `dataError`  out  1  one-cycle pulse on a timed-out data completion.
- `dataBusy`  out  1  load/store not yet complete.
- `memoryRequest`  out  1  transaction outstanding.
- `memoryAddress`  out  32  word-aligned address; bits [1:0] are always 0.
- `memoryWriteEnable`  out  1  store.
- `memoryByteSelect`  out  4  byte lanes.
- `memoryWriteData`  out  32  store data.
- `memoryReadData`  in  32  read data; valid only when `memoryAck` is high.
- `memoryAck`  in  1  completes the outstanding transaction.

## Operation
- **States:** IDLE, FETCH, DATA.
- **Arbitration in IDLE:**
  - `requestingData` high: go to DATA. Data has fixed priority over fetch, because the load/store belongs to the older instruction.
  - Otherwise, `requestingInstruction` high: go to FETCH.
  - Otherwise, stay in IDLE.
- **Register load on leaving IDLE:** `memoryRequest` is set to 1 and the memory-side outputs are loaded from the winning requester.
  - Fetch: `memoryWriteEnable=0`, `memoryByteSelect=4'b1111`, `memoryWriteData=0`.
- **In FETCH or DATA:**
  - The transaction is never pre-empted.
  - `memoryAck` high completes it: `memoryRequest` goes low and the state returns to IDLE.
  - `memoryAck` is ignored while in IDLE.
- **Busy outputs (combinational):**
  - `instructionBusy = requestingInstruction && !(state==FETCH && completing)`.
  - `dataBusy = requestingData && !(state==DATA && completing)`.
  - Busy is therefore high in the same cycle a request first appears.
- **Read data:**
  - In a load completion cycle, `dataReadData` = `memoryReadData`; in a fetch completion cycle, `fetchData` = `memoryReadData`.
  - Each value is also latched and held until that port's next completion.
  - On a timeout completion the output is 0 and the latched value becomes 0.
- **Timeout:**
  - A counter clears on leaving IDLE and increments each cycle `memoryRequest` is high without `memoryAck`.
  - When the count equals `TIMEOUT_CYCLES`, the transaction completes: the busy output drops and the matching error output pulses for one cycle.
  - If `memoryAck` arrives in the same cycle, the ack wins and no error is raised.
- **Requester withdrawal mid-transaction:** the bus transaction still runs to ack or timeout. The result is discarded, but the latched data register is still updated.
- **Reset:** reset mid-transaction returns the state to IDLE immediately, with `memoryRequest` low.

## Timing
- **Reset values:**
  - State IDLE.
  - `memoryRequest`, `memoryWriteEnable`: 0.
  - `memoryAddress`, `memoryByteSelect`, `memoryWriteData`: 0.
  - `fetchData`, `dataReadData`: 0.
  - Error outputs: 0.
  - Busy outputs equal their request inputs.
- **Request path:** a request seen in cycle N drives `memoryRequest` high in cycle N+1.
- **Minimum latency:** an ack in N+1 completes the transaction in N+1, so busy is high in N only (1-cycle stall).
- **Back-to-back:** after a completion the state is IDLE for exactly one cycle before the next transaction, giving a minimum 2-cycle issue spacing.
- **Simultaneous fetch and data in cycle N:**
  - DATA issues in N+1.
  - FETCH issues one cycle after the DATA completion.
  - `instructionBusy` stays high throughout.
- **Input stability:** address and data inputs are sampled only on the IDLE→FETCH/DATA transition. Later changes have no effect on the outstanding transaction.

## Structure
- **Shared package `core_memory_pkg`:**
  - 2-bit state enum {IDLE, FETCH, DATA}.
  - `FULL_WORD_SELECT = 4'b1111`.
  - Timeout counter width `$clog2(TIMEOUT_CYCLES+1)`.
- **Sub-module `memory_timeout_counter`:** inputs clear and run; output expired.
- **Size:** roughly 200 lines of RTL in total.

## Test plan
- **Single fetch:** `fetchAddress=0x1003`, ack 3 cycles after `memoryRequest`, `memoryReadData=0xDEADBEEF`.
  - `memoryAddress=0x1000`, byte select 4'b1111.
  - `instructionBusy` high 4 cycles.
  - `fetchData=0xDEADBEEF`, held afterwards.
- **Simultaneous requests:** store (`0x2000`, data `0x12345678`, byte select 4'b0011) and a fetch in the same cycle.
  - Store issues first.
  - Fetch issues one cycle after the store ack.
  - `dataBusy` drops at the store ack; `instructionBusy` drops at the fetch ack.
- **Timeout:** `TIMEOUT_CYCLES=4`, load with no ack.
  - `memoryRequest` high 4 cycles, then low.
  - `dataError` pulses once, `dataReadData=0`.
  - Ack arriving exactly on cycle 4: no error, read data passed through.
- **Withdrawal:** `requestingInstruction` drops while in FETCH.
  - Transaction completes on ack.
  - No new request is issued.
  - The next fetch issues normally.
- **Reset mid-DATA:** `rst` low for 1 cycle.
  - `memoryRequest`=0 immediately.
  - All outputs at reset values.
  - A following request restarts cleanly.
